// File: rtl/spdif_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spdif_pkg                                                        |
// | Purpose  : Shared types, slot constants and small helpers for the S/PDIF    |
// |            subframe decoder (interval codes, preamble codes, order rule).   |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package spdif_pkg;

    // Preamble code as presented on preamble_o
    typedef enum logic [1:0] {
        PRE_NONE = 2'd0,
        PRE_B    = 2'd1,
        PRE_M    = 2'd2,
        PRE_W    = 2'd3
    } preamble_t;

    // Classified length of the interval between two line transitions
    typedef enum logic [1:0] {
        IV_SHORT = 2'd0,
        IV_MID   = 2'd1,
        IV_LONG  = 2'd2,
        IV_BAD   = 2'd3
    } interval_t;

    localparam int SLOT_DATA_FIRST   = 4;
    localparam int SLOT_V            = 28;
    localparam int SLOT_U            = 29;
    localparam int SLOT_C            = 30;
    localparam int SLOT_P            = 31;
    localparam int BITS_PER_SUBFRAME = 28;

    // Exactly one class flag must be set; anything else is a code violation
    function automatic interval_t classify(input logic s, input logic m, input logic l);
        case ({s, m, l})
            3'b100:  classify = IV_SHORT;
            3'b010:  classify = IV_MID;
            3'b001:  classify = IV_LONG;
            default: classify = IV_BAD;
        endcase
    endfunction

    // The first interval after the leading long selects the preamble candidate
    function automatic preamble_t pre_from_first(input interval_t iv);
        case (iv)
            IV_SHORT: pre_from_first = PRE_B;
            IV_LONG:  pre_from_first = PRE_M;
            IV_MID:   pre_from_first = PRE_W;
            default:  pre_from_first = PRE_NONE;
        endcase
    endfunction

    // The middle interval is always short; the last one disambiguates
    function automatic interval_t pre_third(input preamble_t p);
        case (p)
            PRE_B:   pre_third = IV_LONG;
            PRE_M:   pre_third = IV_SHORT;
            PRE_W:   pre_third = IV_MID;
            default: pre_third = IV_BAD;
        endcase
    endfunction

    // Legal subframe ordering: B->W, W->M|B, M->W
    function automatic logic order_ok(input preamble_t prev, input preamble_t cur);
        case (prev)
            PRE_B:   order_ok = (cur == PRE_W);
            PRE_W:   order_ok = (cur == PRE_M) || (cur == PRE_B);
            PRE_M:   order_ok = (cur == PRE_W);
            default: order_ok = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/spdif_lock_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spdif_lock_tracker                                               |
// | Purpose  : Loss-of-signal watchdog, subframe order check and good-subframe  |
// |            counter driving the receiver lock flag.                          |
// | Ports    : clk_i, nrst_i        clock / async active-low reset              |
// |            i_ena                interval strobe from the edge detector      |
// |            i_emit, i_pre        subframe completed this cycle + its type    |
// |            i_parity_err         parity result of the completing subframe    |
// |            i_cv                 code violation seen this cycle              |
// |            o_lock               registered lock flag                        |
// |            o_timeout            watchdog expiry term (combinational)        |
// |            o_order_err          order violation term (combinational)        |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module spdif_lock_tracker
    import spdif_pkg::*;
#(
    parameter int LOCK_CNT    = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic      clk_i,
    input  logic      nrst_i,
    input  logic      i_ena,
    input  logic      i_emit,
    input  preamble_t i_pre,
    input  logic      i_parity_err,
    input  logic      i_cv,
    output logic      o_lock,
    output logic      o_timeout,
    output logic      o_order_err
);

    localparam int c_wd_w = $clog2(TIMEOUT_CYC + 1);
    localparam int c_gd_w = $clog2(LOCK_CNT + 1);
    localparam logic [c_wd_w-1:0] c_wd_max  = c_wd_w'(TIMEOUT_CYC);
    localparam logic [c_wd_w-1:0] c_wd_fire = c_wd_w'(TIMEOUT_CYC - 1);
    localparam logic [c_gd_w-1:0] c_gd_max  = c_gd_w'(LOCK_CNT);

    logic [c_wd_w-1:0] r_wd_cnt;
    logic [c_gd_w-1:0] r_good_cnt;
    preamble_t         r_prev_pre;
    logic              r_prev_vld;

    logic w_bad;
    logic w_good;

    // Fires on the cycle the count would reach TIMEOUT_CYC; a strobe in that
    // same cycle reloads the counter instead, so the strobe wins.
    assign o_timeout   = !i_ena && (r_wd_cnt == c_wd_fire);
    // r_prev_vld is cleared on every resync, so the first subframe is exempt
    assign o_order_err = i_emit && r_prev_vld && !order_ok(r_prev_pre, i_pre);

    assign w_bad  = i_cv || o_timeout || (i_emit && (i_parity_err || o_order_err));
    assign w_good = i_emit && !i_parity_err && !o_order_err;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_wd_cnt   <= '0;
            r_good_cnt <= '0;
            r_prev_pre <= PRE_NONE;
            r_prev_vld <= 1'b0;
            o_lock     <= 1'b0;
        end else begin
            // Watchdog saturates so a dead line reports only once
            if (i_ena) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != c_wd_max) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end

            if (i_cv || o_timeout) begin
                r_prev_vld <= 1'b0;
            end else if (i_emit) begin
                r_prev_pre <= i_pre;
                r_prev_vld <= 1'b1;
            end

            // Lock follows the counter one cycle late, but drops immediately
            if (w_bad) begin
                r_good_cnt <= '0;
                o_lock     <= 1'b0;
            end else begin
                if (w_good && (r_good_cnt != c_gd_max)) begin
                    r_good_cnt <= r_good_cnt + 1'b1;
                end
                o_lock <= (r_good_cnt == c_gd_max);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spdif_subframe_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spdif_subframe_decoder                                           |
// | Purpose  : Biphase-mark bit recovery, B/M/W preamble detection and 32-slot  |
// |            subframe assembly from classified interval strobes.              |
// | Ports    : clk_i, nrst_i                 clock / async active-low reset     |
// |            short_i, mid_i, long_i, ena_i interval class + valid strobe      |
// |            data_o, v_o, u_o, c_o         subframe fields (held)             |
// |            parity_err_o, preamble_o      subframe status (held)             |
// |            valid_o                       new subframe strobe                |
// |            lock_o                        receiver locked                    |
// |            err_o                         code/order/timeout error strobe    |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module spdif_subframe_decoder
    import spdif_pkg::*;
#(
    parameter int LOCK_CNT    = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        short_i,
    input  logic        mid_i,
    input  logic        long_i,
    input  logic        ena_i,
    output logic [23:0] data_o,
    output logic        v_o,
    output logic        u_o,
    output logic        c_o,
    output logic        parity_err_o,
    output logic [1:0]  preamble_o,
    output logic        valid_o,
    output logic        lock_o,
    output logic        err_o
);

    localparam logic [1:0] c_st_hunt = 2'd0;
    localparam logic [1:0] c_st_pre  = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;
    localparam logic [1:0] c_st_half = 2'd3;

    localparam int         c_v_idx    = SLOT_V - SLOT_DATA_FIRST;
    localparam int         c_u_idx    = SLOT_U - SLOT_DATA_FIRST;
    localparam int         c_c_idx    = SLOT_C - SLOT_DATA_FIRST;
    localparam logic [4:0] c_last_bit = 5'(BITS_PER_SUBFRAME - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_pre_idx;
    logic        r_need_long;   // subframe just closed; next interval must be long
    preamble_t   r_pre_type;
    logic [26:0] r_shift;       // first 27 bits; the 28th arrives as w_shift_bit
    logic [4:0]  r_bit_cnt;

    interval_t   w_iv;
    logic        w_cv;
    logic        w_shift_en;
    logic        w_shift_bit;
    logic        w_emit;
    logic        w_parity_err;
    logic        w_timeout;
    logic        w_order_err;
    logic [27:0] w_frame;

    assign w_iv         = classify(short_i, mid_i, long_i);
    assign w_frame      = {w_shift_bit, r_shift};   // bit 0 = slot 4
    assign w_emit       = w_shift_en && (r_bit_cnt == c_last_bit);
    assign w_parity_err = ^w_frame;

    always_comb begin
        w_cv        = 1'b0;
        w_shift_en  = 1'b0;
        w_shift_bit = 1'b0;
        if (ena_i) begin
            case (r_state)
                c_st_pre: begin
                    if (r_need_long) begin
                        w_cv = (w_iv != IV_LONG);
                    end else begin
                        case (r_pre_idx)
                            2'd0:    w_cv = (w_iv == IV_BAD);
                            2'd1:    w_cv = (w_iv != IV_SHORT);
                            default: w_cv = (w_iv != pre_third(r_pre_type));
                        endcase
                    end
                end
                c_st_data: begin
                    // A mid is a whole 0 cell; a short opens a 1 cell
                    if (w_iv == IV_MID) begin
                        w_shift_en = 1'b1;
                    end else if (w_iv != IV_SHORT) begin
                        w_cv = 1'b1;
                    end
                end
                c_st_half: begin
                    if (w_iv == IV_SHORT) begin
                        w_shift_en  = 1'b1;
                        w_shift_bit = 1'b1;
                    end else begin
                        w_cv = 1'b1;
                    end
                end
                default: begin
                    // Hunting: everything except a long is ignored
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state      <= c_st_hunt;
            r_pre_idx    <= '0;
            r_need_long  <= 1'b0;
            r_pre_type   <= PRE_NONE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            data_o       <= '0;
            v_o          <= 1'b0;
            u_o          <= 1'b0;
            c_o          <= 1'b0;
            parity_err_o <= 1'b0;
            preamble_o   <= '0;
            valid_o      <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            valid_o <= w_emit;
            err_o   <= w_cv || w_timeout || w_order_err;

            if (w_emit) begin
                data_o       <= w_frame[c_v_idx-1:0];
                v_o          <= w_frame[c_v_idx];
                u_o          <= w_frame[c_u_idx];
                c_o          <= w_frame[c_c_idx];
                parity_err_o <= w_parity_err;
                preamble_o   <= r_pre_type;
            end

            if (w_cv || w_timeout) begin
                r_state     <= c_st_hunt;
                r_need_long <= 1'b0;
                r_pre_idx   <= '0;
                r_bit_cnt   <= '0;
            end else if (ena_i) begin
                case (r_state)
                    c_st_hunt: begin
                        if (w_iv == IV_LONG) begin
                            r_state   <= c_st_pre;
                            r_pre_idx <= '0;
                        end
                    end
                    c_st_pre: begin
                        if (r_need_long) begin
                            r_need_long <= 1'b0;
                        end else if (r_pre_idx == 2'd0) begin
                            r_pre_type <= pre_from_first(w_iv);
                            r_pre_idx  <= 2'd1;
                        end else if (r_pre_idx == 2'd1) begin
                            r_pre_idx <= 2'd2;
                        end else begin
                            r_state   <= c_st_data;
                            r_pre_idx <= '0;
                            r_bit_cnt <= '0;
                        end
                    end
                    default: begin
                        if (w_shift_en) begin
                            r_shift <= {w_shift_bit, r_shift[26:1]};
                            if (w_emit) begin
                                r_state     <= c_st_pre;
                                r_need_long <= 1'b1;
                                r_bit_cnt   <= '0;
                            end else begin
                                r_state   <= c_st_data;
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end else begin
                            r_state <= c_st_half;
                        end
                    end
                endcase
            end
        end
    end

    spdif_lock_tracker #(
        .LOCK_CNT    (LOCK_CNT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_lock_tracker (
        .clk_i        (clk_i),
        .nrst_i       (nrst_i),
        .i_ena        (ena_i),
        .i_emit       (w_emit),
        .i_pre        (r_pre_type),
        .i_parity_err (w_parity_err),
        .i_cv         (w_cv),
        .o_lock       (lock_o),
        .o_timeout    (w_timeout),
        .o_order_err  (w_order_err)
    );

endmodule
`default_nettype wire
